// File: rtl/reorder_buffer_param_pkg.sv
// Shared definitions for the reorder buffer slice: entry kind encodings,
// the "no tag" value and the register-id / default data widths.
package reorder_buffer_param_pkg;

    localparam int REG_ID_W     = 5;
    localparam int XLEN_DEFAULT = 32;
    localparam int ROB_NONE     = 0;   // tag 0 means "no entry"

    typedef enum logic [1:0] {
        KIND_NORMAL = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2
    } rob_kind_e;

endpackage

// File: rtl/reorder_buffer_param_rob_tag_ptr.sv
// Wrapping tag pointer over 1..DEPTH (tag 0 is reserved for "none").
// Ports:
//   clk   - clock
//   clear - synchronous return to tag 1, wins over inc
//   inc   - advance by one, DEPTH wraps to 1
//   ptr   - current tag
module rob_tag_ptr #(
    parameter int DEPTH = 8,
    parameter int IDW   = 4
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           inc,
    output logic [IDW-1:0] ptr
);

    localparam logic [IDW-1:0] FIRST = IDW'(1);
    localparam logic [IDW-1:0] LAST  = IDW'(DEPTH);

    always_ff @(posedge clk) begin
        if (clear) begin
            ptr <= FIRST;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? FIRST : ptr + FIRST;
        end
    end

endmodule

// File: rtl/reorder_buffer_param.sv
// In-order retirement queue. Allocates a tag per issued instruction, captures
// results from two writeback buses, forwards operands (with bus bypass) and
// retires at most one head entry per cycle. A mispredicted branch clears the
// whole buffer on its retire edge.
// Ports:
//   clk, rst, rdy          - clock, sync active-high reset, global enable (0 = freeze)
//   full                   - count >= DEPTH-FULL_MARGIN
//   issue_*                - allocation request; issue_tag is the tag being allocated
//   qj/qk -> vj*/vk*       - combinational operand lookup
//   wb0_*                  - LSB writeback (tag 0 = idle)
//   wb1_*                  - RS writeback with resolved next pc (tag 0 = idle)
//   commit_*               - registered retire report (commit_tag 0 = nothing)
//   st_valid/st_ack        - head-store handshake with the LSB
//   flush_out/flush_pc     - one-cycle mispredict redirect
//   flush_in               - external flush, same effect as reset
module reorder_buffer_param
    import reorder_buffer_param_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int IDW         = 4,
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int FULL_MARGIN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    output logic                full,
    input  logic                issue_valid,
    input  logic [1:0]          issue_kind,
    input  logic [REG_ID_W-1:0] issue_rd,
    input  logic [XLEN-1:0]     issue_pred_pc,
    output logic [IDW-1:0]      issue_tag,
    input  logic [IDW-1:0]      qj,
    input  logic [IDW-1:0]      qk,
    output logic                vj_ready,
    output logic                vk_ready,
    output logic [XLEN-1:0]     vj,
    output logic [XLEN-1:0]     vk,
    input  logic [IDW-1:0]      wb0_tag,
    input  logic [XLEN-1:0]     wb0_val,
    input  logic [IDW-1:0]      wb1_tag,
    input  logic [XLEN-1:0]     wb1_val,
    input  logic [XLEN-1:0]     wb1_npc,
    output logic [IDW-1:0]      commit_tag,
    output logic [REG_ID_W-1:0] commit_rd,
    output logic [XLEN-1:0]     commit_val,
    output logic                st_valid,
    input  logic                st_ack,
    output logic                flush_out,
    output logic [XLEN-1:0]     flush_pc,
    input  logic                flush_in
);

    localparam logic [IDW-1:0] DEPTH_T = IDW'(DEPTH);
    localparam logic [IDW-1:0] FULL_AT = IDW'(DEPTH - FULL_MARGIN);
    localparam logic [IDW-1:0] NONE_T  = IDW'(ROB_NONE);

    logic                e_ready [1:DEPTH];
    rob_kind_e           e_kind  [1:DEPTH];
    logic [REG_ID_W-1:0] e_rd    [1:DEPTH];
    logic [XLEN-1:0]     e_val   [1:DEPTH];
    logic [XLEN-1:0]     e_npc   [1:DEPTH];
    logic [XLEN-1:0]     e_pred  [1:DEPTH];

    logic [IDW-1:0] head, tail, count, count_next;
    logic           flush_all, alloc, head_valid, retire_normal, retire_store;
    logic           retire, mispredict, ptr_clear, wb0_hit, wb1_hit;

    assign flush_all  = rst | flush_in;
    assign alloc      = issue_valid & rdy;
    assign head_valid = (count != NONE_T);
    assign wb0_hit    = (wb0_tag != NONE_T) && (wb0_tag <= DEPTH_T);
    assign wb1_hit    = (wb1_tag != NONE_T) && (wb1_tag <= DEPTH_T);

    // Store handshake: st_valid is high for as long as the head entry is a
    // store. The store retires on a cycle with st_valid & st_ack & rdy;
    // st_ack without st_valid has no effect. The LSB must not assume a
    // pending store survives a flush or reset.
    assign st_valid      = head_valid && (e_kind[head] == KIND_STORE);
    assign retire_store  = st_valid && st_ack;
    assign retire_normal = head_valid && (e_kind[head] != KIND_STORE) && e_ready[head];
    assign retire        = rdy & (retire_normal | retire_store);
    assign mispredict    = rdy && retire_normal && (e_kind[head] == KIND_BRANCH)
                           && (e_npc[head] != e_pred[head]);
    assign ptr_clear     = flush_all | mispredict;

    // Net change stays inside IDW bits: alloc and retire together cancel out.
    assign count_next = count + {{(IDW-1){1'b0}}, alloc} - {{(IDW-1){1'b0}}, retire};
    assign full       = (count >= FULL_AT);
    assign issue_tag  = tail;

    rob_tag_ptr #(.DEPTH(DEPTH), .IDW(IDW)) u_head (
        .clk(clk), .clear(ptr_clear), .inc(retire), .ptr(head)
    );
    rob_tag_ptr #(.DEPTH(DEPTH), .IDW(IDW)) u_tail (
        .clk(clk), .clear(ptr_clear), .inc(alloc), .ptr(tail)
    );

    // Operand lookup: a bus carrying the requested tag this cycle beats the
    // stored entry, so a consumer never misses a result by one cycle.
    function automatic logic [XLEN:0] read_operand(input logic [IDW-1:0] q);
        logic [XLEN:0] r;
        r = '0;
        if (q != NONE_T && q <= DEPTH_T) begin
            if (q == wb0_tag)      r = {1'b1, wb0_val};
            else if (q == wb1_tag) r = {1'b1, wb1_val};
            else                   r = {e_ready[q], e_val[q]};
        end
        return r;
    endfunction

    always_comb begin
        {vj_ready, vj} = read_operand(qj);
        {vk_ready, vk} = read_operand(qk);
    end

    // Control state: occupancy, per-entry ready/kind and the registered outputs.
    always_ff @(posedge clk) begin
        if (flush_all) begin
            count      <= '0;
            commit_tag <= NONE_T;
            commit_rd  <= '0;
            commit_val <= '0;
            flush_out  <= 1'b0;
            flush_pc   <= '0;
            for (int i = 1; i <= DEPTH; i++) begin
                e_ready[i] <= 1'b0;
                e_kind[i]  <= KIND_NORMAL;
            end
        end else if (rdy) begin
            commit_tag <= NONE_T;
            flush_out  <= 1'b0;
            if (retire_normal) begin
                commit_tag <= head;
                commit_rd  <= e_rd[head];
                commit_val <= e_val[head];
            end
            if (mispredict) begin
                // Younger entries and any same-cycle issue are discarded.
                count     <= '0;
                flush_out <= 1'b1;
                flush_pc  <= e_npc[head];
                for (int i = 1; i <= DEPTH; i++) begin
                    e_ready[i] <= 1'b0;
                    e_kind[i]  <= KIND_NORMAL;
                end
            end else begin
                count <= count_next;
                if (alloc) begin
                    // Stores have no result to wait for; only the LSB ack gates them.
                    e_ready[tail] <= (issue_kind == KIND_STORE);
                    e_kind[tail]  <= rob_kind_e'(issue_kind);
                end
                if (wb0_hit) e_ready[wb0_tag] <= 1'b1;
                if (wb1_hit) e_ready[wb1_tag] <= 1'b1;
            end
        end
    end

    // Payload storage; validity is tracked by count/ready, so no reset needed.
    always_ff @(posedge clk) begin
        if (!flush_all && rdy) begin
            if (alloc) begin
                e_rd[tail]   <= issue_rd;
                e_pred[tail] <= issue_pred_pc;
            end
            if (wb0_hit) e_val[wb0_tag] <= wb0_val;
            if (wb1_hit) begin
                e_val[wb1_tag] <= wb1_val;
                e_npc[wb1_tag] <= wb1_npc;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_param.sv
module tb_reorder_buffer_param;

    localparam int DEPTH = 8;
    localparam int IDW   = 4;
    localparam int XLEN  = 32;
    localparam int W     = IDW + 5 + XLEN;

    logic            clk, rst, rdy, full;
    logic            issue_valid;
    logic [1:0]      issue_kind;
    logic [4:0]      issue_rd;
    logic [XLEN-1:0] issue_pred_pc;
    logic [IDW-1:0]  issue_tag, qj, qk;
    logic            vj_ready, vk_ready;
    logic [XLEN-1:0] vj, vk;
    logic [IDW-1:0]  wb0_tag, wb1_tag;
    logic [XLEN-1:0] wb0_val, wb1_val, wb1_npc;
    logic [IDW-1:0]  commit_tag;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_val;
    logic            st_valid, st_ack, flush_out, flush_in;
    logic [XLEN-1:0] flush_pc;

    reorder_buffer_param #(
        .DEPTH(DEPTH), .IDW(IDW), .XLEN(XLEN), .FULL_MARGIN(1)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .full(full),
        .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
        .issue_pred_pc(issue_pred_pc), .issue_tag(issue_tag),
        .qj(qj), .qk(qk), .vj_ready(vj_ready), .vk_ready(vk_ready), .vj(vj), .vk(vk),
        .wb0_tag(wb0_tag), .wb0_val(wb0_val),
        .wb1_tag(wb1_tag), .wb1_val(wb1_val), .wb1_npc(wb1_npc),
        .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_val(commit_val),
        .st_valid(st_valid), .st_ack(st_ack),
        .flush_out(flush_out), .flush_pc(flush_pc), .flush_in(flush_in)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [XLEN-1:0] val_of(input int t);
        return 32'hC0DE_0000 + XLEN'(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1; issue_valid = 0; issue_kind = 0; issue_rd = 0; issue_pred_pc = 0;
        qj = 0; qk = 0; wb0_tag = 0; wb0_val = 0; wb1_tag = 0; wb1_val = 0; wb1_npc = 0;
        st_ack = 0; flush_in = 0;
    endtask

    task automatic push_exp(input int t, input int r, input logic [XLEN-1:0] v);
        exp_q.push_back({IDW'(t), 5'(r), v});
    endtask

    // ---------------- scoreboard: every reported commit pops one entry ----------------
    logic mon_rdy, mon_rst;
    logic [W-1:0] mon_exp;
    always @(posedge clk) begin
        mon_rdy = rdy;
        mon_rst = rst | flush_in;
        #1;
        if (mon_rdy && !mon_rst && commit_tag !== '0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_commit", commit_tag, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_commit", {commit_tag, commit_rd, commit_val}, mon_exp);
            end
        end
    end

    logic [IDW-1:0] wb_order [3];
    int t;

    initial begin
        wb_order = '{4'd2, 4'd1, 4'd3};
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_commit_tag", commit_tag, 0);
        chk("rst_flush_out", flush_out, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_st_valid", st_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_issue_tag", issue_tag, 1);

        // 1: out-of-order writeback, in-order commit on consecutive cycles
        for (int i = 1; i <= 3; i++) begin
            issue_valid = 1; issue_kind = 0; issue_rd = 5'(i);
            #1;
            chk("t1_issue_tag", issue_tag, i);
            push_exp(i, i, val_of(i));
            tick();
        end
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            wb1_tag = wb_order[i]; wb1_val = val_of(int'(wb_order[i]));
            tick();
        end
        wb1_tag = 0;
        chk("t1_commit_a", commit_tag, 1);
        tick(); chk("t1_commit_b", commit_tag, 2);
        tick(); chk("t1_commit_c", commit_tag, 3);
        tick(); chk("t1_commit_idle", commit_tag, 0);

        // 2/3: fill to the full threshold with wrap, then retire+issue and bypass
        for (int i = 0; i < 7; i++) begin
            t = ((3 + i) % 8) + 1;
            issue_valid = 1; issue_kind = 0; issue_rd = 5'(10 + i);
            #1;
            chk("t2_issue_tag", issue_tag, t);
            chk("t2_not_full", full, 0);
            push_exp(t, 10 + i, (t == 5) ? 32'hDEAD : val_of(t));
            tick();
        end
        issue_valid = 0; qj = 5;
        #1;
        chk("t2_full_at_7", full, 1);
        chk("t3_vj_pending", vj_ready, 0);
        qj = 0;
        #1;
        chk("t3_qj0_ready", vj_ready, 0);
        chk("t3_qj0_val", vj, 0);
        wb0_tag = 4; wb0_val = val_of(4); qk = 4;
        #1;
        chk("t3_vk_bypass_ready", vk_ready, 1);
        chk("t3_vk_bypass_val", vk, val_of(4));
        tick();
        issue_valid = 1; issue_rd = 20; wb0_tag = 5; wb0_val = 32'hDEAD; qj = 5; qk = 0;
        #1;
        chk("t2_issue_tag_3", issue_tag, 3);
        chk("t3_vj_bypass_ready", vj_ready, 1);
        chk("t3_vj_bypass_val", vj, 32'hDEAD);
        push_exp(3, 20, val_of(3));
        tick();
        chk("t2_retire_issue_commit", commit_tag, 4);
        chk("t2_full_hold", full, 1);
        issue_valid = 0; wb0_tag = 0; wb0_val = 0;
        #1;
        chk("t3_vj_stored_ready", vj_ready, 1);
        chk("t3_vj_stored_val", vj, 32'hDEAD);
        tick();
        chk("t2_commit_5", commit_tag, 5);
        chk("t2_full_drop", full, 0);
        wb1_tag = 7; wb1_val = val_of(7); qk = 7; qj = 0;
        #1;
        chk("t3_vk_wb1_ready", vk_ready, 1);
        chk("t3_vk_wb1_val", vk, val_of(7));
        tick();
        chk("t2_head_blocked", commit_tag, 0);
        wb1_tag = 0; qk = 0; flush_in = 1;
        tick();
        flush_in = 0;
        exp_q.delete();
        #1;
        chk("flush_in_issue_tag", issue_tag, 1);
        chk("flush_in_full", full, 0);
        chk("flush_in_commit", commit_tag, 0);

        // 4: store at head waits for ack
        issue_valid = 1; issue_kind = 2;
        tick();
        issue_kind = 0; issue_rd = 7;
        #1;
        chk("t4_st_valid", st_valid, 1);
        push_exp(2, 7, val_of(2));
        tick();
        issue_valid = 0; wb1_tag = 2; wb1_val = val_of(2);
        tick();
        wb1_tag = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_hold_st_valid", st_valid, 1);
            chk("t4_hold_commit", commit_tag, 0);
            tick();
        end
        st_ack = 1;
        #1;
        chk("t4_st_valid_at_ack", st_valid, 1);
        tick();
        st_ack = 0;
        chk("t4_store_commit_tag", commit_tag, 0);
        #1;
        chk("t4_st_valid_drop", st_valid, 0);
        tick();
        chk("t4_next_commit", commit_tag, 2);

        // 5: mispredicted branch flushes, correctly predicted one does not
        issue_valid = 1; issue_kind = 1; issue_rd = 9; issue_pred_pc = 32'h100;
        #1;
        chk("t5_issue_tag", issue_tag, 3);
        push_exp(3, 9, val_of(3));
        tick();
        issue_valid = 0; issue_kind = 0; issue_pred_pc = 0;
        wb1_tag = 3; wb1_val = val_of(3); wb1_npc = 32'h200;
        tick();
        wb1_tag = 0; wb1_npc = 0; issue_valid = 1; issue_rd = 11;
        tick();
        chk("t5_br_commit", commit_tag, 3);
        chk("t5_flush_out", flush_out, 1);
        chk("t5_flush_pc", flush_pc, 32'h200);
        issue_valid = 0;
        #1;
        chk("t5_tail_cleared", issue_tag, 1);
        chk("t5_full", full, 0);
        tick();
        chk("t5_flush_pulse_end", flush_out, 0);
        chk("t5_no_commit", commit_tag, 0);
        issue_valid = 1; issue_kind = 1; issue_rd = 12; issue_pred_pc = 32'h300;
        #1;
        chk("t5b_issue_tag", issue_tag, 1);
        push_exp(1, 12, val_of(1));
        tick();
        issue_valid = 0; issue_kind = 0; issue_pred_pc = 0;
        wb1_tag = 1; wb1_val = val_of(1); wb1_npc = 32'h300;
        tick();
        wb1_tag = 0; wb1_npc = 0;
        tick();
        chk("t5b_commit", commit_tag, 1);
        chk("t5b_no_flush", flush_out, 0);
        #1;
        chk("t5b_issue_tag_next", issue_tag, 2);

        // 6: rdy=0 freezes everything; reset mid-store clears outputs
        issue_valid = 1; issue_kind = 0; issue_rd = 13;
        push_exp(2, 13, val_of(2));
        tick();
        rdy = 0; issue_rd = 14; wb1_tag = 2; wb1_val = val_of(2);
        tick(); tick();
        chk("t6_frozen_commit", commit_tag, 0);
        chk("t6_frozen_tail", issue_tag, 3);
        rdy = 1; issue_valid = 0; wb1_tag = 0; qj = 2;
        #1;
        chk("t6_wb_ignored", vj_ready, 0);
        tick();
        chk("t6_no_retire", commit_tag, 0);
        wb1_tag = 2; wb1_val = val_of(2); qj = 0;
        tick();
        wb1_tag = 0;
        tick();
        chk("t6_commit", commit_tag, 2);
        issue_valid = 1; issue_kind = 2;
        tick();
        issue_valid = 0; issue_kind = 0;
        #1;
        chk("t6_st_pending", st_valid, 1);
        rst = 1;
        tick();
        chk("t6_rst_st_valid", st_valid, 0);
        chk("t6_rst_commit", commit_tag, 0);
        chk("t6_rst_flush_out", flush_out, 0);
        chk("t6_rst_flush_pc", flush_pc, 0);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_issue_tag", issue_tag, 1);
        rst = 0;
        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
